// File: rtl/seg7_scan_driver.sv
// Purpose: time-multiplexed scanner/decoder for a common-anode 7-segment display.
// Latency: seg/an are registered and lag scan_idx by 1 cycle; a load shows on the following update.
// Backpressure: none; load is a single-cycle capture strobe, and enable=0 darkens the display and holds the scan.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int DW = $clog2(REFRESH_DIV)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_en,
  input  logic                    lz_blank,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SW-1:0]           scan_idx
);

  localparam logic [DW-1:0] DIV_LAST  = DW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_DASH  = 7'b0111111;
  localparam logic [6:0]    SEG_BLANK = 7'b1111111;

  logic [DW-1:0]           div_q, div_d;
  logic [SW-1:0]           scan_q, scan_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  // Nibble to active-low g..a pattern; in BCD mode values 10..15 show a dash.
  function automatic logic [6:0] decode(input logic [3:0] n, input logic hex);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'b1000000;
      4'h1: r = 7'b1111001;
      4'h2: r = 7'b0100100;
      4'h3: r = 7'b0110000;
      4'h4: r = 7'b0011001;
      4'h5: r = 7'b0010010;
      4'h6: r = 7'b0000010;
      4'h7: r = 7'b1111000;
      4'h8: r = 7'b0000000;
      4'h9: r = 7'b0010000;
      4'hA: r = hex ? 7'b0001000 : SEG_DASH;
      4'hB: r = hex ? 7'b0000011 : SEG_DASH;
      4'hC: r = hex ? 7'b1000110 : SEG_DASH;
      4'hD: r = hex ? 7'b0100001 : SEG_DASH;
      4'hE: r = hex ? 7'b0000110 : SEG_DASH;
      default: r = hex ? 7'b0001110 : SEG_DASH;
    endcase
    return r;
  endfunction

  // Refresh divider and digit pointer; both freeze while disabled.
  always_comb begin
    div_d  = div_q;
    scan_d = scan_q;
    if (enable) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Shadow capture is independent of enable so the value can be staged while dark.
  always_comb begin
    shadow_d = load ? digits_in : shadow_q;
    dp_d     = load ? dp_in     : dp_q;
  end

  // Next display pattern for the currently selected digit, including leading-zero blanking.
  always_comb begin
    logic [3:0] nib;
    logic       dp_bit;
    logic       blank;
    logic       zacc;
    nib    = '0;
    dp_bit = 1'b0;
    blank  = 1'b0;
    zacc   = 1'b1;
    seg_d  = 8'hFF;
    an_d   = '1;
    // Walk from the most significant digit down: zacc is set while everything at/above i is zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zacc = zacc && (shadow_q[4*i +: 4] == 4'h0);
      if (scan_q == SW'(i)) begin
        nib    = shadow_q[4*i +: 4];
        dp_bit = dp_q[i];
        blank  = lz_blank && zacc && (i != 0);
      end
    end
    if (enable) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_d[k] = ~(scan_q == SW'(k));
      end
      seg_d = {~dp_bit, blank ? SEG_BLANK : decode(nib, hex_en)};
    end
  end

  // State and output registers; reset leaves the display dark at digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      scan_q   <= '0;
      shadow_q <= '0;
      dp_q     <= '0;
      seg_q    <= 8'hFF;
      an_q     <= '1;
    end else begin
      div_q    <= div_d;
      scan_q   <= scan_d;
      shadow_q <= shadow_d;
      dp_q     <= dp_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign scan_idx = scan_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with NUM_DIGITS=8, REFRESH_DIV=4.
// A behavioural model predicts seg/an/scan_idx every cycle; directed scenarios add literal checks.
// Inputs are driven on the falling edge; outputs are compared on the falling edge.
module tb_seg7_scan_driver;
  localparam int ND = 8;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        hex_en = 1'b0;
  logic        lz_blank = 1'b0;
  logic [31:0] digits_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic [2:0]  scan_idx;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load),
    .digits_in(digits_in), .dp_in(dp_in), .hex_en(hex_en), .lz_blank(lz_blank),
    .seg(seg), .an(an), .scan_idx(scan_idx)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model state
  int          m_div = 0;
  int          m_scan = 0;
  logic [31:0] m_sh = '0;
  logic [7:0]  m_dp = '0;
  logic [7:0]  exp_seg = 8'hFF;
  logic [7:0]  exp_an = 8'hFF;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [7:0] model_seg(logic [31:0] sh, logic [7:0] dp, int idx, bit hex, bit lz);
    logic [31:0] upper;
    int          n;
    logic [6:0]  g;
    upper = sh >> (4 * idx);
    n = int'(upper & 32'hF);
    if (lz && idx > 0 && upper == 32'h0) g = 7'h7F;
    else if (!hex && n >= 10)            g = 7'b0111111;
    else                                 g = seg_tab[n];
    return {~dp[idx], g};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: outputs follow the previous cycle's digit pointer and shadow.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_div = 0; m_scan = 0; m_sh = '0; m_dp = '0;
      exp_an = 8'hFF; exp_seg = 8'hFF;
    end else begin
      if (enable) begin
        exp_an  = ~(8'b1 << m_scan);
        exp_seg = model_seg(m_sh, m_dp, m_scan, hex_en, lz_blank);
      end else begin
        exp_an = 8'hFF; exp_seg = 8'hFF;
      end
      if (load) begin m_sh = digits_in; m_dp = dp_in; end
      if (enable) begin
        if (m_div == RD - 1) begin m_div = 0; m_scan = (m_scan + 1) % ND; end
        else m_div++;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("an_model", an, exp_an);
      check("seg_model", seg, exp_seg);
      check("scan_model", scan_idx, 32'(m_scan));
    end
  end

  // Advance to the falling edge where digit k is driven (bounded).
  task automatic wait_an(input int k);
    logic [7:0] want;
    int n;
    want = ~(8'b1 << k);
    n = 0;
    while (an !== want && n < 200) begin @(negedge clk); n++; end
    if (an !== want) check("wait_an_timeout", an, want);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_list [8];

  initial begin
    // Pin the model with hand-derived patterns
    check("pin_bcd4_lz", model_seg(32'h1234, 8'h04, 0, 1'b0, 1'b1), 8'h99);
    check("pin_dp2",     model_seg(32'h1234, 8'h04, 2, 1'b0, 1'b1), 8'h24);
    check("pin_blank4",  model_seg(32'h1234, 8'h04, 4, 1'b0, 1'b1), 8'hFF);
    check("pin_hexD",    model_seg(32'hABCD, 8'h00, 0, 1'b1, 1'b1), 8'hA1);
    check("pin_dash",    model_seg(32'hABCD, 8'h00, 3, 1'b0, 1'b1), 8'hBF);

    // Reset
    #1 rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 8'hFF);
    check("rst_scan", scan_idx, 0);
    rst = 1'b0; enable = 1'b1;
    @(negedge clk);
    check("first_an", an, 8'hFE);
    check("first_seg", seg, 8'hC0);

    // Idle scan of zeros without blanking
    for (int k = 0; k < ND; k++) begin
      wait_an(k);
      check("zero_scan_seg", seg, 8'hC0);
    end

    // BCD with blanking and a decimal point
    @(negedge clk);
    load = 1'b1; digits_in = 32'h0000_1234; dp_in = 8'h04; lz_blank = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    exp_list = '{8'h99, 8'hB0, 8'h24, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int k = 0; k < ND; k++) begin
      wait_an(k);
      check("bcd_lz_seg", seg, exp_list[k]);
    end

    // Hex then BCD-dash decode
    load = 1'b1; digits_in = 32'h0000_ABCD; dp_in = 8'h00; hex_en = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    exp_list = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int k = 0; k < ND; k++) begin
      wait_an(k);
      check("hex_seg", seg, exp_list[k]);
    end
    hex_en = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      wait_an(k);
      check("bcd_dash_seg", seg, 8'hBF);
    end

    // Disable mid-slot at digit 5
    begin
      int n = 0;
      while (scan_idx !== 3'd5 && n < 200) begin @(negedge clk); n++; end
      check("reach_scan5", scan_idx, 5);
    end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_an", an, 8'hFF);
    check("dis_seg", seg, 8'hFF);
    check("dis_scan", scan_idx, 5);
    repeat (3) @(negedge clk);
    check("dis_hold_scan", scan_idx, 5);
    enable = 1'b1;
    @(negedge clk);
    check("resume_an", an, 8'hDF);
    repeat (10) @(negedge clk);

    // Load coinciding with the wrap from digit 7 to 0
    begin
      int n = 0;
      while (!(scan_idx === 3'd7 && m_div == RD - 1) && n < 200) begin @(negedge clk); n++; end
      check("reach_wrap", scan_idx, 7);
    end
    load = 1'b1; digits_in = 32'h0000_0009; dp_in = 8'h00;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("wrap_load_an", an, 8'hFE);
    check("wrap_load_seg", seg, 8'h90);

    // Async reset pulse between clock edges
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_an", an, 8'hFF);
    check("arst_seg", seg, 8'hFF);
    check("arst_scan", scan_idx, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("arst_rel_an", an, 8'hFE);
    check("arst_rel_seg", seg, 8'hC0);

    // Randomized traffic against the model
    repeat (800) begin
      @(negedge clk);
      load = ($urandom % 6) == 0;
      if (load) begin
        digits_in = $urandom >> $urandom_range(0, 31);
        dp_in = 8'($urandom);
      end
      if (($urandom % 8) == 0) hex_en = ~hex_en;
      if (($urandom % 8) == 0) lz_blank = ~lz_blank;
      enable = ($urandom % 10) != 0;
      if (($urandom % 150) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a NUM_DIGITS-digit common-anode seven-segment display.
- Captures a packed digit word on a load strobe and scans one digit at a time at a programmable refresh rate.
- Decodes each digit in BCD or hex mode, with leading-zero blanking and per-digit decimal points.
- Sits between the stopwatch counter/formatting logic and the board's seg/an pins; replaces per-digit combinational decode with a single registered scanner.

Parameters:
- NUM_DIGITS, 8, number of scanned digits (1..8).
- REFRESH_DIV, 100000, clk cycles per digit slot (>=2); 100000 gives a 1 kHz digit rate at 100 MHz.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = scan; 0 = display dark and counters held.
- load  in  1  single-cycle strobe; captures digits_in and dp_in.
- digits_in  in  4*NUM_DIGITS  packed nibbles; nibble 0 = rightmost digit (an[0]).
- dp_in  in  NUM_DIGITS  per-digit decimal point, 1 = lit.
- hex_en  in  1  1 = hex decode, 0 = BCD decode.
- lz_blank  in  1  1 = blank leading zeros.
- seg  out  8  active-low cathodes; seg[7] = dp, seg[6:0] = g..a.
- an  out  NUM_DIGITS  active-low anodes, one-hot-low.
- scan_idx  out  max(1,$clog2(NUM_DIGITS))  currently selected digit.

Behaviour:
- Reset (async, rst=1):
  - div counter = 0, scan_idx = 0.
  - shadow digit and dp registers = 0.
  - an = all ones, seg = 8'hFF.
  - Outputs stay held while rst=1; deasserting mid-scan restarts from digit 0.
- Capture: on a clk edge with load=1, shadow <= digits_in and dp_shadow <= dp_in. Independent of enable. The capture is visible on seg at the next registered output update, 1 cycle later.
- Divider:
  - When enable=1, div counts 0..REFRESH_DIV-1.
  - On the edge where div == REFRESH_DIV-1: div <= 0 and scan_idx <= (scan_idx == NUM_DIGITS-1) ? 0 : scan_idx+1.
  - When enable=0, div and scan_idx hold.
- Output register: seg/an are registered from (scan_idx, shadow, dp_shadow, hex_en, lz_blank, enable), so they lag scan_idx by exactly 1 cycle.
  - enable=0: next edge an = all ones, seg = 8'hFF.
  - enable=1: an[k] = 0 only for k = scan_idx.
- Decode of nibble n = shadow[4*scan_idx +: 4], seg[6:0]:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - hex_en=1: A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
  - hex_en=0 and n >= 10: dash 0111111, flagging an invalid BCD digit.
- Leading-zero blanking: when lz_blank=1, digit i (i >= 1) is blanked if nibbles i..NUM_DIGITS-1 are all zero. A blanked digit has seg[6:0] = 1111111.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - A nonzero nibble always shows, even when hex_en=0 and it decodes as a dash.
- Decimal point: seg[7] = ~dp_shadow[scan_idx]. This applies to blanked digits too.
- Simultaneous events:
  - load on the same edge as a scan advance: the new shadow and new scan_idx both take effect, and the output register uses them on the following edge.
  - Mode inputs (hex_en, lz_blank) changing mid-slot take effect at the next edge.
- NUM_DIGITS=1: scan_idx is constantly 0 and an[0] = 0 while enabled.

Test Plan (REFRESH_DIV=4, NUM_DIGITS=8):
- Reset, then rst=0, enable=1, no load: an cycles FE, FD, FB, ..., 7F, FE with 4 cycles per digit; seg = 8'hC0 on an[0] and 8'hC0 on all other digits (lz_blank=0).
- load digits_in=32'h00001234, lz_blank=1, dp_in=8'h04: digits 0..3 show 8'h99, 8'hB0, 8'h24 (dp on), 8'hF9; digits 4..7 show 8'hFF.
- digits_in=32'h0000ABCD, hex_en=1, then hex_en=0: with hex_en=1, digit 0 shows 8'hA1 and digit 3 shows 8'h88. With hex_en=0, digits 0..3 show 8'hBF.
- enable=0 mid-slot at scan_idx=5: next cycle an = 8'hFF, seg = 8'hFF, scan_idx stays 5. enable=1 resumes at 5 with div unchanged.
- load asserted on the wrap edge (scan_idx 7 -> 0) with digits_in=32'h00000009: the cycle after, an = 8'hFE and seg = 8'h90.
- Async rst pulse between clk edges during scan: an = 8'hFF and seg = 8'hFF immediately, scan_idx = 0, shadow cleared; after release, digit 0 shows 8'hC0.
